// File: rtl/uart_frac_baud_gen.sv
// Fractional baud-rate generator: oversample, bit and mid-bit ticks from a
// runtime-loadable integer.fraction divisor. The fractional part is spread by
// an accumulator whose carry stretches the next oversample period by one clock,
// so the long-term average period is exact and never drifts.
module uart_frac_baud_gen #(
  parameter int DIV_INT_WIDTH    = 16,
  parameter int DIV_FRAC_WIDTH   = 4,
  parameter int OVERSAMPLE       = 16,
  parameter int DEFAULT_DIV_INT  = 27,
  parameter int DEFAULT_DIV_FRAC = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          en,
  input  logic [DIV_INT_WIDTH-1:0]      div_int,
  input  logic [DIV_FRAC_WIDTH-1:0]     div_frac,
  input  logic                          div_load,
  input  logic                          phase_clr,
  output logic                          baud_tick_os,
  output logic                          baud_tick,
  output logic                          mid_tick,
  output logic [$clog2(OVERSAMPLE)-1:0] os_index,
  output logic                          div_busy
);

  localparam int OS_W = $clog2(OVERSAMPLE);
  localparam logic [OS_W-1:0] OS_LAST = OS_W'(OVERSAMPLE - 1);
  localparam logic [OS_W-1:0] OS_MID  = OS_W'(OVERSAMPLE / 2);

  logic [DIV_INT_WIDTH-1:0]  r_cnt;
  logic [DIV_FRAC_WIDTH-1:0] r_acc;
  logic                      r_carry;
  logic [OS_W-1:0]           r_os_idx;
  logic [DIV_INT_WIDTH-1:0]  r_int_act;
  logic [DIV_FRAC_WIDTH-1:0] r_frac_act;
  logic [DIV_INT_WIDTH-1:0]  r_int_pend;
  logic [DIV_FRAC_WIDTH-1:0] r_frac_pend;
  logic                      r_busy;
  logic                      r_tick_os;
  logic                      r_tick;
  logic                      r_mid;

  logic [DIV_INT_WIDTH-1:0]  w_int_eff;
  logic [DIV_INT_WIDTH:0]    w_period_m1;
  logic                      w_wrap;
  logic                      w_emit;
  logic [DIV_FRAC_WIDTH:0]   w_acc_sum;
  logic [OS_W-1:0]           w_os_next;
  logic                      w_activate;

  // A zero divisor behaves as one; the carry from the last wrap adds a clock.
  assign w_int_eff   = (r_int_act == '0) ? DIV_INT_WIDTH'(1) : r_int_act;
  assign w_period_m1 = {1'b0, w_int_eff - DIV_INT_WIDTH'(1)} + {{DIV_INT_WIDTH{1'b0}}, r_carry};
  // >= rather than == so a divisor shrunk while frozen mid-period still wraps.
  assign w_wrap      = en & ({1'b0, r_cnt} >= w_period_m1);
  assign w_emit      = w_wrap & ~phase_clr;
  assign w_acc_sum   = {1'b0, r_acc} + {1'b0, r_frac_act};
  assign w_os_next   = r_os_idx + OS_W'(1);
  // Pending divisor takes over at a period boundary, when frozen, or on realign.
  assign w_activate  = r_busy & (w_wrap | ~en | phase_clr);

  // Phase state: period counter, fractional accumulator and oversample slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_acc    <= '0;
      r_carry  <= 1'b0;
      r_os_idx <= '0;
    end else if (phase_clr) begin
      r_cnt    <= '0;
      r_acc    <= '0;
      r_carry  <= 1'b0;
      r_os_idx <= '0;
    end else if (w_wrap) begin
      r_cnt            <= '0;
      {r_carry, r_acc} <= w_acc_sum;
      r_os_idx         <= w_os_next;
    end else if (en) begin
      r_cnt <= r_cnt + DIV_INT_WIDTH'(1);
    end
  end

  // Registered tick pulses, one cycle after the wrap edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tick_os <= 1'b0;
      r_tick    <= 1'b0;
      r_mid     <= 1'b0;
    end else begin
      r_tick_os <= w_emit;
      r_tick    <= w_emit & (r_os_idx == OS_LAST);
      r_mid     <= w_emit & (w_os_next == OS_MID);
    end
  end

  // Divisor capture (pending) and hand-over to the active divisor.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_int_act   <= DIV_INT_WIDTH'(DEFAULT_DIV_INT);
      r_frac_act  <= DIV_FRAC_WIDTH'(DEFAULT_DIV_FRAC);
      r_int_pend  <= DIV_INT_WIDTH'(DEFAULT_DIV_INT);
      r_frac_pend <= DIV_FRAC_WIDTH'(DEFAULT_DIV_FRAC);
      r_busy      <= 1'b0;
    end else if (div_load && phase_clr) begin
      r_int_act   <= div_int;
      r_frac_act  <= div_frac;
      r_int_pend  <= div_int;
      r_frac_pend <= div_frac;
      r_busy      <= 1'b0;
    end else begin
      if (w_activate) begin
        r_int_act  <= r_int_pend;
        r_frac_act <= r_frac_pend;
      end
      if (div_load) begin
        r_int_pend  <= div_int;
        r_frac_pend <= div_frac;
        r_busy      <= 1'b1;
      end else if (w_activate) begin
        r_busy <= 1'b0;
      end
    end
  end

  assign baud_tick_os = r_tick_os;
  assign baud_tick    = r_tick;
  assign mid_tick     = r_mid;
  assign os_index     = r_os_idx;
  assign div_busy     = r_busy;

endmodule

// File: doc/uart_frac_baud_gen.md
Name: uart_frac_baud_gen

Overview:
Programmable fractional baud-rate generator for the UART TX/RX datapaths, replacing the fixed integer 16x divider. It produces an oversample tick, a bit tick and a mid-bit tick. The divisor is runtime-loadable, with an integer part and a fractional part, and the oversampling ratio is a parameter. A phase-clear input lets the RX realign the tick grid to a detected start bit.

Parameters:
DIV_INT_WIDTH, 16, width of integer divisor (clocks per oversample tick)
DIV_FRAC_WIDTH, 4, width of fractional divisor (units of 1/2^DIV_FRAC_WIDTH clock)
OVERSAMPLE, 16, oversample ticks per bit; power of two, 4..64
DEFAULT_DIV_INT, 27, integer divisor after reset (50 MHz / (115200*16) = 27.13)
DEFAULT_DIV_FRAC, 2, fractional divisor after reset (2/16 = 0.125)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
en  in  1  count enable; low freezes all counters
div_int  in  DIV_INT_WIDTH  new integer divisor
div_frac  in  DIV_FRAC_WIDTH  new fractional divisor
div_load  in  1  one-cycle strobe; captures div_int/div_frac into the pending registers
phase_clr  in  1  synchronous realign of all phase state
baud_tick_os  out  1  one-cycle pulse per oversample period
baud_tick  out  1  one-cycle pulse per bit (every OVERSAMPLE-th os tick)
mid_tick  out  1  one-cycle pulse at os_index == OVERSAMPLE/2 (bit centre)
os_index  out  $clog2(OVERSAMPLE)  current oversample slot, 0..OVERSAMPLE-1
div_busy  out  1  high while a loaded divisor is pending and not yet active

Behaviour:
- Reset (rst_n low, async):
  - cnt=0, acc=0, os_index=0, carry=0.
  - Active and pending divisor = DEFAULT_DIV_INT/DEFAULT_DIV_FRAC.
  - All tick outputs 0; div_busy 0.
- Period:
  - P = max(div_int_active,1) + carry, where carry comes from the previous wrap.
  - div_int 0 is treated as 1.
- Counting, en=1:
  - cnt increments each clk.
  - When cnt == P-1 (the wrap): cnt<=0; {carry,acc} <= acc + div_frac_active (DIV_FRAC_WIDTH+1 bit add, carry used for the next P); os_index <= os_index+1 mod OVERSAMPLE.
- Outputs:
  - Registered. baud_tick_os is high for exactly the one cycle following each wrap edge.
  - baud_tick is high in the same cycle as baud_tick_os when os_index goes OVERSAMPLE-1 -> 0.
  - mid_tick is high in the same cycle as baud_tick_os when os_index becomes OVERSAMPLE/2.
  - Outputs are never high for two consecutive cycles unless P==1.
- Average period = div_int + div_frac/2^DIV_FRAC_WIDTH clocks. The error never accumulates: over 2^DIV_FRAC_WIDTH os ticks the total is exactly div_int*2^F + div_frac clocks.
- First tick: baud_tick_os is first high in cycle P after the first cycle with en=1 after reset release.
- div_load:
  - Writes the pending registers and sets div_busy.
  - The pending divisor becomes active on the next wrap and is used for the period starting there; div_busy clears on that edge.
  - If en=0, it becomes active on the following clk.
  - A second div_load before activation overwrites pending (last wins).
  - acc is not cleared on a divisor change.
- phase_clr:
  - On the next edge: cnt=0, acc=0, carry=0, os_index=0, all ticks 0.
  - Overrides a coincident wrap (no tick is emitted, and os_index does not advance).
  - A pending divisor is activated by phase_clr.
  - The next baud_tick_os follows P cycles later.
- en=0: cnt, acc, os_index hold; tick outputs forced 0 next cycle; div_load still captured.
- Simultaneous div_load and phase_clr: the newly loaded value becomes active immediately.
- Reset mid-operation: all state returns to reset values asynchronously; ticks drop the same instant.

Test Plan:
- Integer mode, OVERSAMPLE=16: div_load 4/0, en=1 -> baud_tick_os every 4 clk, mid_tick at os tick 8, baud_tick every 64 clk, os_index 0..15 wrapping.
- Fractional, F=4: div_load 4/8 -> periods alternate 4,5,4,5; 32 os ticks span exactly 144 clk; baud_tick spacing 72 clk.
- Defaults after reset (27/2) -> 16 os ticks = 434 clk ±1; 256 os ticks = exactly 6944 clk.
- div_load 10/0 issued at cnt=1 of a 4-cycle period -> current period ends at 4 and the next period is 10; div_busy is high for exactly those remaining cycles.
- phase_clr coincident with a wrap at os_index=15 -> no baud_tick, os_index=0, next baud_tick_os 4 clk later.
- en low for 7 cycles mid-period -> tick delayed by exactly 7; div_int=0 -> baud_tick_os every clk; rst_n low mid-count -> all outputs 0 immediately, defaults restored.
